nes_reader: RTL

NES_READER -- requirements
Module: nes_reader

---
 rtl/nes_reader_if.sv | 21 ++
 rtl/nes_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/nes_reader_if.sv
// NES controller reader signal bundle: host-side enable/data in, latch/clock
// strobes and decoded button frame out.
interface nes_reader_if;
  logic       en;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  modport master (
    output en, nes_data,
    input  nes_latch, nes_clk, buttons, valid, busy
  );

  modport slave (
    input  en, nes_data,
    output nes_latch, nes_clk, buttons, valid, busy
  );
endinterface

// File: rtl/nes_reader.sv
// Periodic NES controller poller: latches the pad, shifts out 8 active-low
// bits on a 6 us tick grid and presents them as an active-high button byte.
module nes_reader #(
  parameter int TICK_CYCLES = 600,
  parameter int POLL_TICKS  = 2778,
  parameter int TICK_W      = 10,
  parameter int POLL_W      = 12
) (
  input  logic         clk,
  input  logic         reset,
  nes_reader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tcnt_q, tcnt_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                half_q, half_d;
  logic                latch_q, latch_d;
  logic                nclk_q, nclk_d;
  logic [7:0]          buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                run, tick;

  // Tick timebase keeps running through a frame even if en drops.
  assign run  = bus.en || (state_q != IDLE);
  assign tick = run && (tcnt_q == TICK_W'(TICK_CYCLES - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (run) tcnt_d = tick ? '0 : tcnt_q + TICK_W'(1);
  end

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    half_d  = half_q;
    case (state_q)
      IDLE: begin
        if (tick && bus.en) begin
          if (poll_q == POLL_W'(POLL_TICKS - 1)) begin
            poll_d  = '0;
            half_d  = 1'b0;
            state_d = LATCH;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
      end
      LATCH: begin
        if (tick) begin
          if (half_q) begin
            shift_d[0] = bus.nes_data;
            idx_d      = 3'd1;
            state_d    = CLK_HI;
          end else begin
            half_d = 1'b1;
          end
        end
      end
      CLK_HI: begin
        if (tick) begin
          shift_d[idx_q] = bus.nes_data;
          state_d        = CLK_LO;
        end
      end
      CLK_LO: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = CLK_HI;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it exactly.
  always_comb begin
    latch_d   = (state_d == LATCH);
    nclk_d    = (state_d == CLK_HI);
    valid_d   = (state_d == DONE);
    buttons_d = (state_d == DONE) ? ~shift_q : buttons_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      poll_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      half_q    <= 1'b0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      poll_q    <= poll_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      half_q    <= half_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.nes_latch = latch_q;
  assign bus.nes_clk   = nclk_q;
  assign bus.buttons   = buttons_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
